// File: rtl/sha256_round_engine_if.sv
// Block-feed / digest bus for sha256_round_engine.
// The master (upstream feed logic) presents a block and a chaining value with
// a start request. The slave (round engine) reports busy, a one-cycle done
// pulse and the resulting hash.
//   start    : request, only honoured while the engine is idle
//   block_in : 512-bit message block, word0 in [511:480]
//   hash_in  : 256-bit chaining value, H0 in [255:224]
//   busy     : engine is running rounds or the final addition
//   done     : one-cycle pulse, hash_out valid from this cycle on
//   hash_out : 256-bit result, held until the next completed block
interface sha256_round_engine_if;
  logic         start;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  modport master (
    output start, block_in, hash_in,
    input  busy, done, hash_out
  );

  modport slave (
    input  start, block_in, hash_in,
    output busy, done, hash_out
  );
endinterface

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core, one round per clock.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : block-feed / digest bus (slave side)
//   k_in  : round constant returned combinationally by the K ROM
//   k_sel : K ROM index, round counter while running rounds, else K_SEL_IDLE
// The message schedule is kept as a 16-word sliding window: W[0] is the word
// consumed this round and W[15] receives the next expanded word.
module sha256_round_engine #(
  parameter int         NUM_ROUNDS = 64,
  parameter logic [6:0] K_SEL_IDLE = 7'h7F
) (
  input  logic                       clk,
  input  logic                       rst,
  sha256_round_engine_if.slave       bus,
  input  logic [31:0]                k_in,
  output logic [6:0]                 k_sel
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  localparam logic [6:0] LAST_RND = 7'(NUM_ROUNDS - 1);

  logic [1:0]   state_reg;
  logic [6:0]   rnd_reg;
  logic         done_reg;
  logic [255:0] hash_out_reg;
  logic [31:0]  wv_reg [0:7];   // working variables a..h
  logic [31:0]  hs_reg [0:7];   // chaining value saved at start
  logic [31:0]  w_reg  [0:15];  // message schedule window

  logic [31:0]  hin_w  [0:7];
  logic [31:0]  blk_w  [0:15];
  logic [255:0] final_sum;
  logic [31:0]  t1, t2, w_new;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Unpack the big-endian buses into words and pack the final sum back.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_hash_words
      assign hin_w[gi] = bus.hash_in[255 - 32*gi -: 32];
      assign final_sum[255 - 32*gi -: 32] = hs_reg[gi] + wv_reg[gi];
    end
    for (gi = 0; gi < 16; gi++) begin : g_block_words
      assign blk_w[gi] = bus.block_in[511 - 32*gi -: 32];
    end
  endgenerate

  // Round datapath: a=wv[0] ... h=wv[7]
  assign t1 = wv_reg[7] + big_sigma1(wv_reg[4])
            + ((wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]))
            + k_in + w_reg[0];
  assign t2 = big_sigma0(wv_reg[0])
            + ((wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]));

  // Expanding every round is harmless: words produced after round 47 are
  // never consumed, so no special case for the first 16 rounds is needed.
  assign w_new = small_sigma1(w_reg[14]) + w_reg[9] + small_sigma0(w_reg[1]) + w_reg[0];

  assign k_sel        = (state_reg == ROUND) ? rnd_reg : K_SEL_IDLE;
  assign bus.busy     = (state_reg == ROUND) || (state_reg == FINAL);
  assign bus.done     = done_reg;
  assign bus.hash_out = hash_out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rnd_reg      <= 7'd0;
      done_reg     <= 1'b0;
      hash_out_reg <= '0;
      for (int i = 0; i < 8; i++) begin
        wv_reg[i] <= '0;
        hs_reg[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_reg[i] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 8; i++) begin
              hs_reg[i] <= hin_w[i];
              wv_reg[i] <= hin_w[i];
            end
            for (int i = 0; i < 16; i++) begin
              w_reg[i] <= blk_w[i];
            end
            rnd_reg   <= 7'd0;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          wv_reg[0] <= t1 + t2;
          wv_reg[1] <= wv_reg[0];
          wv_reg[2] <= wv_reg[1];
          wv_reg[3] <= wv_reg[2];
          wv_reg[4] <= wv_reg[3] + t1;
          wv_reg[5] <= wv_reg[4];
          wv_reg[6] <= wv_reg[5];
          wv_reg[7] <= wv_reg[6];
          for (int i = 0; i < 15; i++) begin
            w_reg[i] <= w_reg[i + 1];
          end
          w_reg[15] <= w_new;
          rnd_reg   <= rnd_reg + 7'd1;
          if (rnd_reg == LAST_RND) begin
            state_reg <= FINAL;
          end
        end
        FINAL: begin
          hash_out_reg <= final_sum;
          done_reg     <= 1'b1;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_EXP = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] TWO_EXP = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic        clk;
  logic        rst;
  logic [31:0] k_in;
  logic [6:0]  k_sel;

  sha256_round_engine_if bus ();

  sha256_round_engine dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .k_in  (k_in),
    .k_sel (k_sel)
  );

  // K constant ROM: combinational, zero outside the table
  assign k_in = (k_sel < 7'd64) ? K_TAB[k_sel[5:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int blocks_expected = 0;
  logic [255:0] exp_q [$];
  logic [255:0] last_exp = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: straightforward FIPS 180-4 compression on a full W[0..63]
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
    logic [31:0] w [0:63];
    logic [31:0] v [0:8];
    logic [31:0] s0, s1, ch, maj, tt1, tt2;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    v[8] = '0;
    for (int t = 0; t < 64; t++) begin
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      tt1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ch + K_TAB[t] + w[t];
      tt2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + maj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + tt1;
      v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
    return res;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, required none");
      end else begin
        logic [255:0] e;
        e = exp_q.pop_front();
        chk("hash_out", bus.hash_out, e);
        $display("block %0d hash_out=%h", done_cnt, bus.hash_out);
      end
    end
  end

  // Called at a falling edge; drives start, walks the block cycle by cycle.
  // abort_at >= 0 asserts rst at that round. glitch pulses start at rnd 10/63.
  task automatic run_block(input logic [511:0] blk, input logic [255:0] hin,
                           input logic [255:0] exp, input int abort_at, input bit glitch);
    bus.block_in = blk;
    bus.hash_in  = hin;
    bus.start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.block_in = rand_block();
    bus.hash_in  = rand_hash();
    for (int r = 0; r < 64; r++) begin
      @(negedge clk);
      chk("k_sel_round", {249'b0, k_sel}, r);
      chk("busy_round", {255'b0, bus.busy}, 1);
      if (r == 0 || r == 63) begin
        chk("done_round", {255'b0, bus.done}, 0);
        chk("hash_held", bus.hash_out, last_exp);
      end
      if (r == abort_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {255'b0, bus.busy}, 0);
        chk("rst_done", {255'b0, bus.done}, 0);
        chk("rst_hash", bus.hash_out, 0);
        chk("rst_k_sel", {249'b0, k_sel}, 256'h7f);
        void'(exp_q.pop_back());
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      bus.start = glitch && (r == 10 || r == 63);
      if (bus.start) begin
        bus.block_in = rand_block();
        bus.hash_in  = rand_hash();
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("k_sel_final", {249'b0, k_sel}, 256'h7f);
    chk("busy_final", {255'b0, bus.busy}, 1);
    chk("done_final", {255'b0, bus.done}, 0);
    @(negedge clk);
    chk("done_pulse", {255'b0, bus.done}, 1);
    chk("busy_done", {255'b0, bus.busy}, 0);
    chk("k_sel_idle", {249'b0, k_sel}, 256'h7f);
    blocks_expected++;
    last_exp = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    logic [255:0] hin;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.block_in = '0;
    bus.hash_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {255'b0, bus.busy}, 0);
    chk("reset_done", {255'b0, bus.done}, 0);
    chk("reset_hash", bus.hash_out, 0);
    chk("reset_k_sel", {249'b0, k_sel}, 256'h7f);
    rst = 1'b0;
    @(negedge clk);

    run_block(EMPTY_BLK, IV, EMPTY_EXP, -1, 1'b0);
    @(negedge clk);
    run_block(ABC_BLK, IV, ABC_EXP, 30, 1'b0);
    run_block(ABC_BLK, IV, ABC_EXP, -1, 1'b0);
    @(negedge clk);

    // two-block chain, second block started in the done cycle of the first
    run_block(TWO_B1, IV, ref_compress(TWO_B1, IV), -1, 1'b0);
    run_block(TWO_B2, bus.hash_out, TWO_EXP, -1, 1'b0);
    @(negedge clk);

    // starts while busy are ignored
    run_block(ABC_BLK, IV, ABC_EXP, -1, 1'b1);

    for (int n = 0; n < 6; n++) begin
      blk = rand_block();
      hin = (n % 3 == 0) ? IV : rand_hash();
      if (n % 2 == 1) @(negedge clk);
      run_block(blk, hin, ref_compress(blk, hin), -1, n == 4);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("done_count", done_cnt, blocks_expected);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
